// File: rtl/demod_mode_sched.sv
// Automatic AM/ASK/FM mode controller: windowed envelope statistics, confirmed
// classification and a muted, debounced mode-select switch sequence.
module demod_mode_sched #(
  parameter int WIN_LEN    = 1024,
  parameter int SIG_THR    = 16,
  parameter int FLAT_THR   = 24,
  parameter int CONFIRM    = 3,
  parameter int MUTE_CYC   = 16,
  parameter int SETTLE_MAX = 4096
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       env_valid,
  input  logic [7:0] env_data,
  input  logic       manual_en,
  input  logic [1:0] manual_mode,
  input  logic       dp_ready,
  output logic [1:0] mode_select,
  output logic       mute,
  output logic       mode_valid,
  output logic [3:0] status_led
);

  localparam int CW  = $clog2(WIN_LEN) + 1;
  localparam int CFW = $clog2(CONFIRM + 1);
  localparam int MW  = $clog2(MUTE_CYC + 1);
  localparam int SW  = $clog2(SETTLE_MAX + 1);

  localparam logic [CW-1:0]  WIN_LAST    = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0]  WIN_QUARTER = CW'(WIN_LEN / 4);
  localparam logic [CFW-1:0] CONF_N      = CFW'(CONFIRM);
  localparam logic [MW-1:0]  MUTE_LAST   = MW'(MUTE_CYC - 1);
  localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_MAX - 1);
  localparam logic [7:0]     SIG_T       = 8'(SIG_THR);
  localparam logic [7:0]     FLAT_T      = 8'(FLAT_THR);

  localparam logic [1:0] MODE_AM  = 2'b00;
  localparam logic [1:0] MODE_ASK = 2'b01;
  localparam logic [1:0] MODE_FM  = 2'b10;

  typedef enum logic [2:0] {
    ST_MEASURE,
    ST_EVAL,
    ST_MUTE,
    ST_SWITCH,
    ST_SETTLE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   smp_cnt, mid_cnt;
  logic [7:0]      win_max, win_min;
  logic [7:0]      band_lo, band_hi;
  logic            band_valid;
  logic [1:0]      cand_prev;
  logic [CFW-1:0]  confirm_cnt;
  logic [1:0]      target;
  logic [MW-1:0]   mute_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            sig_present, timeout_flag;
  logic            manual_en_q;

  // Combinational decisions shared by the FSM and the datapath registers.
  logic [7:0]     depth, quarter;
  logic           sig_ok, has_cand, man_fall, man_req, in_ctrl;
  logic [1:0]     cand;
  logic [CFW-1:0] conf_inc;
  logic           eval_cls, switch_now, go_mute, settle_done;
  logic           win_clr, band_clr, acc_en;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    depth    = win_max - win_min;
    quarter  = depth >> 2;
    sig_ok   = (win_max >= SIG_T);
    has_cand = 1'b1;
    cand     = mode_select;
    if (sig_ok) begin
      if (depth < FLAT_T)         cand = MODE_FM;
      else if (!band_valid)       has_cand = 1'b0;
      else if (mid_cnt < WIN_QUARTER) cand = MODE_ASK;
      else                        cand = MODE_AM;
    end
    conf_inc = (cand == cand_prev) ? confirm_cnt + 1'b1 : CFW'(1);

    in_ctrl     = (state == ST_MEASURE) || (state == ST_EVAL);
    man_fall    = manual_en_q && !manual_en;
    man_req     = manual_en && (manual_mode != mode_select);
    eval_cls    = (state == ST_EVAL) && !manual_en;
    switch_now  = eval_cls && has_cand && (cand != mode_select) && (conf_inc == CONF_N);
    go_mute     = (in_ctrl && man_req) || switch_now;
    settle_done = (state == ST_SETTLE) && (dp_ready || settle_cnt == SETTLE_LAST);

    band_clr = ((state == ST_MEASURE) && man_fall) || settle_done;
    win_clr  = band_clr || (state == ST_EVAL);
    acc_en   = (state == ST_MEASURE) && !manual_en && !man_fall && env_valid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_MEASURE: begin
        if (go_mute) state_nxt = ST_MUTE;
        else if (acc_en && smp_cnt == WIN_LAST) state_nxt = ST_EVAL;
      end
      ST_EVAL:   state_nxt = go_mute ? ST_MUTE : ST_MEASURE;
      ST_MUTE:   if (mute_cnt == MUTE_LAST) state_nxt = ST_SWITCH;
      ST_SWITCH: state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_nxt = ST_MEASURE;
      default:   state_nxt = ST_MEASURE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_MEASURE;
    else            state <= state_nxt;
  end

  // Window statistics; min starts at all-ones so the first sample always loads it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      smp_cnt <= '0;
      mid_cnt <= '0;
      win_max <= '0;
      win_min <= '1;
    end else if (win_clr) begin
      smp_cnt <= '0;
      mid_cnt <= '0;
      win_max <= '0;
      win_min <= '1;
    end else if (acc_en) begin
      smp_cnt <= smp_cnt + 1'b1;
      if (env_data > win_max) win_max <= env_data;
      if (env_data < win_min) win_min <= env_data;
      if (band_valid && env_data >= band_lo && env_data <= band_hi)
        mid_cnt <= mid_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      band_lo     <= '0;
      band_hi     <= '0;
      band_valid  <= 1'b0;
      cand_prev   <= MODE_AM;
      confirm_cnt <= '0;
      sig_present <= 1'b0;
      manual_en_q <= 1'b0;
    end else begin
      manual_en_q <= manual_en;
      if (band_clr) begin
        band_valid  <= 1'b0;
        confirm_cnt <= '0;
      end else if (eval_cls) begin
        band_lo     <= win_min + quarter;
        band_hi     <= win_max - quarter;
        band_valid  <= 1'b1;
        sig_present <= sig_ok;
        if (has_cand) begin
          cand_prev   <= cand;
          confirm_cnt <= (cand == mode_select) ? '0 : conf_inc;
        end
      end
    end
  end

  // Switch sequence: mode_select is presented during SWITCH, mute drops the clock after SETTLE exits.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      target       <= MODE_AM;
      mode_select  <= MODE_AM;
      mode_valid   <= 1'b0;
      mute         <= 1'b0;
      mute_cnt     <= '0;
      settle_cnt   <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (in_ctrl && manual_en && !man_req && !mode_valid) mode_valid <= 1'b1;
      if (go_mute) begin
        target   <= man_req ? manual_mode : cand;
        mute     <= 1'b1;
        mute_cnt <= '0;
      end
      case (state)
        ST_MUTE: begin
          mute_cnt <= mute_cnt + 1'b1;
          if (mute_cnt == MUTE_LAST) begin
            mode_select <= target;
            mode_valid  <= 1'b1;
          end
        end
        ST_SWITCH: settle_cnt <= '0;
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_done) begin
            mute <= 1'b0;
            if (!dp_ready) timeout_flag <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign status_led = {timeout_flag, sig_present, mode_select};

endmodule

// File: tb/tb_demod_mode_sched.sv
// Scoreboard bench for demod_mode_sched: expected switch sequences are queued
// with the stimulus and matched against each observed mute pulse.
module tb_demod_mode_sched;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       env_valid = 1'b0;
  logic [7:0] env_data = '0;
  logic       manual_en = 1'b0;
  logic [1:0] manual_mode = '0;
  logic       dp_ready = 1'b1;
  logic [1:0] mode_select;
  logic       mute, mode_valid;
  logic [3:0] status_led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] mode;
    int         pre;   // mute-high cycles before mode_select changes
    int         post;  // mute-high cycles from the change until mute falls
  } sw_t;
  sw_t sb[$];

  localparam int K_CONST100 = 0, K_SQUARE = 1, K_SINE = 2, K_CONST10 = 3, K_ALT = 4;

  demod_mode_sched #(.WIN_LEN(64)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .env_valid(env_valid), .env_data(env_data),
    .manual_en(manual_en), .manual_mode(manual_mode), .dp_ready(dp_ready),
    .mode_select(mode_select), .mute(mute), .mode_valid(mode_valid),
    .status_led(status_led)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: measures each mute pulse and matches it against the queue.
  logic       prev_mute = 1'b0;
  logic [1:0] prev_mode = '0;
  logic       changed = 1'b0;
  int         pre_n = 0, post_n = 0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_mute = 1'b0; prev_mode = '0; changed = 1'b0; pre_n = 0; post_n = 0;
    end else begin
      if (mode_select != prev_mode) changed = 1'b1;
      if (mute) begin
        if (changed) post_n++;
        else         pre_n++;
      end
      if (!mute && prev_mute) begin
        if (sb.size() == 0) begin
          check("unexpected_switch", 1, 0);
        end else begin
          sw_t e;
          e = sb.pop_front();
          check("sw_mode", mode_select, e.mode);
          check("sw_pre_mute", pre_n, e.pre);
          check("sw_post_mute", post_n, e.post);
        end
        pre_n = 0; post_n = 0; changed = 1'b0;
      end
      prev_mute = mute;
      prev_mode = mode_select;
    end
  end

  function automatic logic [7:0] sample(input int kind, input int c, input int i);
    real r;
    case (kind)
      K_CONST100: return 8'd100;
      K_SQUARE:   return ((i / 8) % 2) ? 8'd200 : 8'd20;
      K_SINE: begin
        r = 110.0 + 90.0 * $sin(2.0 * 3.14159265358979 * (i % 32) / 32.0);
        return 8'(int'(r));
      end
      K_CONST10:  return 8'd10;
      default:    return (c % 2) ? (((i / 8) % 2) ? 8'd200 : 8'd20) : 8'd100;
    endcase
  endfunction

  // One chunk = 64 accepted samples plus the EVAL cycle, so chunks track DUT windows.
  task automatic drive_chunks(input int kind, input int n);
    for (int c = 0; c < n; c++)
      for (int i = 0; i < 65; i++) begin
        @(negedge sys_clk);
        env_valid = 1'b1;
        env_data  = sample(kind, c, i);
      end
    @(negedge sys_clk);
    env_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    sb.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic push(input logic [1:0] mode, input int pre, input int post);
    sw_t e;
    e.mode = mode; e.pre = pre; e.post = post;
    sb.push_back(e);
  endtask

  task automatic wait_sb(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    do_reset();
    check("rst_mode", mode_select, 2'b00);
    check("rst_mute", mute, 1'b0);
    check("rst_valid", mode_valid, 1'b0);
    check("rst_led", status_led, 4'b0000);

    // Constant envelope -> FM after three windows.
    push(2'b10, 16, 2);
    drive_chunks(K_CONST100, 5);
    wait_sb(200);
    check("fm_mode", mode_select, 2'b10);
    check("fm_valid", mode_valid, 1'b1);
    check("fm_led", status_led, 4'b0110);

    // Square envelope -> ASK (first window only builds the band).
    do_reset();
    push(2'b01, 16, 2);
    drive_chunks(K_SQUARE, 6);
    wait_sb(200);
    check("ask_mode", mode_select, 2'b01);
    check("ask_valid", mode_valid, 1'b1);
    check("ask_led", status_led, 4'b0101);

    // Sine envelope -> AM, already current, no mute pulse.
    do_reset();
    drive_chunks(K_SINE, 6);
    check("am_mode", mode_select, 2'b00);
    check("am_led", status_led, 4'b0100);
    check("am_mute", mute, 1'b0);
    check("am_valid", mode_valid, 1'b0);

    // Weak envelope -> no signal.
    do_reset();
    drive_chunks(K_CONST10, 4);
    check("nosig_led", status_led, 4'b0000);
    check("nosig_mute", mute, 1'b0);

    // Alternating FM/ASK candidates never confirm.
    do_reset();
    drive_chunks(K_ALT, 7);
    check("alt_mode", mode_select, 2'b00);
    check("alt_mute", mute, 1'b0);

    // Manual 11 with dp_ready low -> settle timeout, sticky flag.
    do_reset();
    dp_ready    = 1'b0;
    manual_mode = 2'b11;
    manual_en   = 1'b1;
    push(2'b11, 16, 4097);
    wait_sb(5000);
    check("man_mode", mode_select, 2'b11);
    check("man_led_timeout", status_led, 4'b1011);
    repeat (50) @(negedge sys_clk);
    check("man_led_sticky", status_led, 4'b1011);
    check("man_no_retrigger", mute, 1'b0);
    manual_en = 1'b0;
    dp_ready  = 1'b1;
    do_reset();
    check("man_led_cleared", status_led, 4'b0000);

    // Manual request equal to the current mode only marks it valid.
    manual_mode = 2'b00;
    manual_en   = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("eq_valid", mode_valid, 1'b1);
    check("eq_mute", mute, 1'b0);
    manual_en = 1'b0;

    // Reset in the middle of MUTE, then measurement restarts.
    do_reset();
    manual_mode = 2'b10;
    manual_en   = 1'b1;
    repeat (5) @(negedge sys_clk);
    check("midmute_mute_hi", mute, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("midmute_mute", mute, 1'b0);
    check("midmute_mode", mode_select, 2'b00);
    check("midmute_valid", mode_valid, 1'b0);
    manual_en = 1'b0;
    sb.delete();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    push(2'b10, 16, 2);
    drive_chunks(K_CONST100, 5);
    wait_sb(200);
    check("restart_mode", mode_select, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
